demux2_64bit_reg: RTL and testbench

Registered 1:2 demultiplexer for 64-bit words. It accepts one word per cycle on a valid/ready input and steers it, according to a select bit, into one of two one-entry output slots. Each slot presents its word on its own valid/ready output and counts the words it delivers. It is the receiving-side counterpart of the 2:1 word mux in the datapath: the mux merges two word sources, and this block splits one word stream back into two.

---
 rtl/demux2_64bit_reg_pkg.sv | 13 +
 rtl/demux_slot.sv | 44 ++++
 rtl/demux2_64bit_reg.sv | 67 ++++++
 tb/tb_demux2_64bit_reg.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux2_64bit_reg_pkg.sv
// demux2_64bit_reg shared definitions.
// Default widths and slot state encoding.
package demux2_64bit_reg_pkg;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_CNT_W = 16;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot of the 1:2 word demux.
// Holds a word, its valid state and a delivered-word counter.
module demux_slot
   import demux2_64bit_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             drain,
   output logic             can_accept,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] cnt
);

   slot_state_e state;

   assign valid      = (state == SLOT_FULL);
   assign can_accept = (state == SLOT_EMPTY) || drain;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= SLOT_EMPTY;
         data  <= '0;
         cnt   <= '0;
      end else begin
         // A load wins over a drain: the slot refills in the same cycle.
         if (load) begin
            state <= SLOT_FULL;
            data  <= load_data;
         end else if (drain) begin
            state <= SLOT_EMPTY;
         end
         if (drain) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux2_64bit_reg.sv
// Registered 1:2 word demultiplexer.
// Select decode and in_ready mux over two demux_slot instances.
module demux2_64bit_reg
   import demux2_64bit_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   logic acc0, acc1;
   logic load0, load1;
   logic drain0, drain1;
   logic in_fire;

   assign drain0   = out0_valid && out0_ready;
   assign drain1   = out1_valid && out1_ready;
   assign in_ready = in_sel ? acc1 : acc0;
   assign in_fire  = in_valid && in_ready;
   assign load0    = in_fire && !in_sel;
   assign load1    = in_fire && in_sel;

   demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_slot0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load0),
      .load_data  (in_data),
      .drain      (drain0),
      .can_accept (acc0),
      .valid      (out0_valid),
      .data       (out0_data),
      .cnt        (cnt0)
   );

   demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_slot1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load1),
      .load_data  (in_data),
      .drain      (drain1),
      .can_accept (acc1),
      .valid      (out1_valid),
      .data       (out1_data),
      .cnt        (cnt1)
   );

endmodule

// File: tb/tb_demux2_64bit_reg.sv
// Bench for demux2_64bit_reg with CNT_W = 4.
// Scoreboard queues per port plus directed scenario tasks.
module tb_demux2_64bit_reg;

   localparam int W  = 64;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          in_sel;
   logic          out0_valid, out1_valid;
   logic          out0_ready, out1_ready;
   logic [W-1:0]  out0_data, out1_data;
   logic [CW-1:0] cnt0, cnt1;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0]  q0[$];
   logic [W-1:0]  q1[$];
   logic          mv0 = 1'b0, mv1 = 1'b0;
   logic [CW-1:0] mc0 = '0, mc1 = '0;

   demux2_64bit_reg #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   always #5 clk = ~clk;

   // Reference model, evaluated mid-cycle; its state is what the next edge should produce.
   always @(negedge clk) begin
      logic exp_rdy, d0, d1, ld;
      logic [W-1:0] w;
      if (!rst_n) begin
         mv0 = 1'b0; mv1 = 1'b0;
         mc0 = '0;   mc1 = '0;
         q0.delete(); q1.delete();
      end else begin
         n_vec++;
         if (out0_valid !== mv0) begin
            n_err++; $display("FAIL sb_valid0 got %b want %b", out0_valid, mv0);
         end
         n_vec++;
         if (out1_valid !== mv1) begin
            n_err++; $display("FAIL sb_valid1 got %b want %b", out1_valid, mv1);
         end
         n_vec++;
         if (cnt0 !== mc0 || cnt1 !== mc1) begin
            n_err++;
            $display("FAIL sb_cnt got %0d/%0d want %0d/%0d", cnt0, cnt1, mc0, mc1);
         end
         exp_rdy = in_sel ? (!mv1 || out1_ready) : (!mv0 || out0_ready);
         n_vec++;
         if (in_ready !== exp_rdy) begin
            n_err++; $display("FAIL sb_in_ready got %b want %b", in_ready, exp_rdy);
         end
         d0 = mv0 && out0_ready;
         d1 = mv1 && out1_ready;
         if (d0) begin
            n_vec++;
            if (q0.size() == 0) begin
               n_err++; $display("FAIL sb_port0 got %h want <none>", out0_data);
            end else begin
               w = q0.pop_front();
               if (out0_data !== w) begin
                  n_err++; $display("FAIL sb_port0 got %h want %h", out0_data, w);
               end
            end
            mc0 = mc0 + 1'b1;
         end
         if (d1) begin
            n_vec++;
            if (q1.size() == 0) begin
               n_err++; $display("FAIL sb_port1 got %h want <none>", out1_data);
            end else begin
               w = q1.pop_front();
               if (out1_data !== w) begin
                  n_err++; $display("FAIL sb_port1 got %h want %h", out1_data, w);
               end
            end
            mc1 = mc1 + 1'b1;
         end
         ld = in_valid && exp_rdy;
         if (ld && !in_sel) q0.push_back(in_data);
         if (ld && in_sel)  q1.push_back(in_data);
         mv0 = (ld && !in_sel) ? 1'b1 : (d0 ? 1'b0 : mv0);
         mv1 = (ld && in_sel)  ? 1'b1 : (d1 ? 1'b0 : mv1);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h5555;
      out0_ready = 1'b1; out1_ready = 1'b1;
      do_reset(2);
      in_valid = 1'b0;
      #1;
      n_vec++;
      if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
         n_err++; $display("FAIL rst_valid got %b%b want 00", out0_valid, out1_valid);
      end
      n_vec++;
      if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin
         n_err++; $display("FAIL rst_cnt got %0d/%0d want 0/0", cnt0, cnt1);
      end
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready);
      end
      n_vec++;
      if (out0_data !== '0 || out1_data !== '0) begin
         n_err++; $display("FAIL rst_data got %h/%h want 0/0", out0_data, out1_data);
      end
   endtask

   task automatic test_basic();
      out0_ready = 1'b1; out1_ready = 1'b1;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hDEADBEEF_00000001;
      cyc();
      n_vec++;
      if (out0_valid !== 1'b1 || out0_data !== 64'hDEADBEEF_00000001 || out1_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_p0 got v%b%b d%h want v10 d%h", out0_valid, out1_valid, out0_data,
                  64'hDEADBEEF_00000001);
      end
      in_sel = 1'b1; in_data = 64'hCAFEF00D_00000002;
      cyc();
      n_vec++;
      if (out1_valid !== 1'b1 || out1_data !== 64'hCAFEF00D_00000002 || out0_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_p1 got v%b%b d%h want v01 d%h", out0_valid, out1_valid, out1_data,
                  64'hCAFEF00D_00000002);
      end
      in_valid = 1'b0;
      cyc();
      n_vec++;
      if (cnt0 !== 4'd1 || cnt1 !== 4'd1) begin
         n_err++; $display("FAIL basic_cnt got %0d/%0d want 1/1", cnt0, cnt1);
      end
   endtask

   task automatic test_backpressure();
      out0_ready = 1'b0; out1_ready = 1'b1;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h1;
      cyc();
      in_data = 64'h2;
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL bp_in_ready got %b want 0", in_ready);
      end
      cyc();
      n_vec++;
      if (out0_valid !== 1'b1 || out0_data !== 64'h1) begin
         n_err++; $display("FAIL bp_hold got v%b d%h want v1 d1", out0_valid, out0_data);
      end
      in_sel = 1'b1; in_data = 64'h3;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_other_ready got %b want 1", in_ready);
      end
      cyc();
      n_vec++;
      if (out1_valid !== 1'b1 || out1_data !== 64'h3 || out0_data !== 64'h1) begin
         n_err++;
         $display("FAIL bp_other got v%b d%h d0 %h want v1 d3 d0 1", out1_valid, out1_data,
                  out0_data);
      end
      in_valid = 1'b0; out0_ready = 1'b1;
      cyc();
   endtask

   task automatic test_drain_load();
      logic [CW-1:0] c;
      out0_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hA;
      cyc();
      c = mc0;
      out0_ready = 1'b1; in_data = 64'hB;
      cyc();
      c = c + 1'b1;
      n_vec++;
      if (out0_valid !== 1'b1 || out0_data !== 64'hB || cnt0 !== c) begin
         n_err++;
         $display("FAIL dl got v%b d%h c%0d want v1 dB c%0d", out0_valid, out0_data, cnt0, c);
      end
      in_valid = 1'b0;
      cyc();
   endtask

   task automatic test_stream_wrap();
      in_valid = 1'b0;
      do_reset(1);
      out1_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_data = 64'h100 + 64'(i);
         #1;
         n_vec++;
         if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL stream_ready i=%0d got %b want 1", i, in_ready);
         end
         cyc();
         if (i == 15 || i == 16) begin
            n_vec++;
            if (cnt1 !== 4'(i)) begin
               n_err++; $display("FAIL stream_cnt i=%0d got %0d want %0d", i, cnt1, 4'(i));
            end
         end
      end
      in_valid = 1'b0;
      cyc();
      n_vec++;
      if (cnt1 !== 4'd1 || out1_valid !== 1'b0) begin
         n_err++; $display("FAIL stream_end got c%0d v%b want c1 v0", cnt1, out1_valid);
      end
   endtask

   task automatic test_reset_mid();
      out0_ready = 1'b0; out1_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h77;
      cyc();
      in_sel = 1'b1; in_data = 64'h88;
      cyc();
      n_vec++;
      if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin
         n_err++; $display("FAIL mid_full got %b%b want 11", out0_valid, out1_valid);
      end
      out0_ready = 1'b1; out1_ready = 1'b1;
      do_reset(1);
      in_valid = 1'b0;
      #1;
      n_vec++;
      if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || cnt0 !== 4'd0 || cnt1 !== 4'd0) begin
         n_err++;
         $display("FAIL mid_rst got v%b%b c%0d/%0d want v00 c0/0", out0_valid, out1_valid,
                  cnt0, cnt1);
      end
      cyc();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
      out0_ready = 1'b0; out1_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_drain_load();
      test_stream_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
